// File: rtl/quiz3_digitales_if.sv
// Push-button side bus of the enable controller: arm, count, finish inputs and the load enable.
interface quiz3_digitales_if;
  logic a;
  logic b;
  logic finished;
  logic encender;

  modport master (output a, output b, output finished, input encender);
  modport slave  (input a, input b, input finished, output encender);
endinterface

// File: rtl/quiz3_digitales.sv
// Sequence-controlled enable: a rising edge on a arms, N_PULSES rising edges on b switch
// the load on, and finished returns to idle.
module quiz3_digitales #(
  parameter int N_PULSES = 3
) (
  input  logic             clk,
  input  logic             rst,
  quiz3_digitales_if.slave bus
);
  localparam int CW = $clog2(N_PULSES + 1);
  localparam logic [CW-1:0] LAST = CW'(N_PULSES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] ON    = 2'd2;

  logic          a_q, b_q;
  logic          a_rise, b_rise;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          encender_q;

  // Inputs are already synchronous; a cleared history makes a level held through reset an edge.
  assign a_rise = bus.a & ~a_q;
  assign b_rise = bus.b & ~b_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (a_rise) begin
          state_d = ARMED;
          cnt_d   = '0;
        end
      end
      ARMED: begin
        if (bus.finished) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (a_rise) begin
          cnt_d = '0;
        end else if (b_rise) begin
          if (cnt_q == LAST) begin
            state_d = ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ON: begin
        if (bus.finished) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      encender_q <= 1'b0;
    end else begin
      a_q        <= bus.a;
      b_q        <= bus.b;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      encender_q <= (state_d == ON);
    end
  end

  assign bus.encender = encender_q;
endmodule

// File: tb/tb_quiz3_digitales.sv
// Bench for quiz3_digitales: directed vector table, reset corner cases and random traffic
// compared against an event-level model of the arm/count/finish rules.
module tb_quiz3_digitales;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  quiz3_digitales_if bus();
  quiz3_digitales #(.N_PULSES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Model: armed flag, count of b edges seen since arming, load-on flag, previous input levels.
  bit m_armed, m_on, m_pa, m_pb;
  int m_cnt;

  typedef struct {
    bit a;
    bit b;
    bit f;
    bit enc;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit a, bit b, bit f, bit enc);
    vec_t v;
    v.a = a; v.b = b; v.f = f; v.enc = enc;
    tbl.push_back(v);
  endfunction

  task automatic model_reset();
    m_armed = 0; m_on = 0; m_pa = 0; m_pb = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit a, input bit b, input bit f);
    bit ar, br;
    ar = a && !m_pa;
    br = b && !m_pb;
    m_pa = a;
    m_pb = b;
    if (m_on) begin
      if (f) m_on = 0;
    end else if (m_armed) begin
      if (f) m_armed = 0;
      else if (ar) m_cnt = 0;
      else if (br) begin
        m_cnt++;
        if (m_cnt == N) begin
          m_armed = 0;
          m_on    = 1;
        end
      end
    end else if (ar) begin
      m_armed = 1;
      m_cnt   = 0;
    end
  endtask

  task automatic check(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: encender=%b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input bit a, input bit b, input bit f);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.finished = f;
    @(posedge clk);
    model_step(a, b, f);
    #1;
  endtask

  initial begin
    // nominal + ignored inputs in ON
    add(1,0,0,0); add(0,0,0,0);
    add(0,1,0,0); add(0,1,0,0); add(0,0,0,0); add(0,0,0,0);
    add(0,1,0,0); add(0,1,0,0); add(0,0,0,0); add(0,0,0,0);
    add(0,1,0,1); add(0,0,0,1); add(1,1,0,1); add(0,0,0,1);
    add(0,0,1,0); add(0,0,0,0);
    // restart on simultaneous a/b edge at cnt=2, then finished with final b aborts
    add(1,0,0,0); add(0,1,0,0); add(0,0,0,0); add(0,1,0,0); add(0,0,0,0);
    add(1,1,0,0); add(0,0,0,0); add(0,1,0,0); add(0,0,0,0); add(0,1,0,0); add(0,0,0,0);
    add(0,1,1,0); add(0,0,0,0);
    // b edges in IDLE ignored; arming works while finished is high
    add(0,1,0,0); add(0,0,0,0); add(0,1,0,0); add(0,0,0,0); add(0,1,0,0); add(0,0,0,0);
    add(1,0,1,0); add(0,1,0,0); add(0,0,0,0); add(0,1,0,0); add(0,0,0,0);
    add(0,1,0,1); add(0,0,0,1); add(0,0,1,0);
    // back-to-back b edges
    add(1,0,0,0); add(0,1,0,0); add(0,0,0,0); add(0,1,0,0); add(0,0,0,0);
    add(0,1,0,1); add(0,0,1,0);
    // a held high is one edge, not a restart
    add(1,0,0,0); add(1,1,0,0); add(1,0,0,0); add(1,1,0,0); add(0,0,0,0);
    add(0,1,0,1); add(0,0,1,0);

    // reset with a and b held high
    bus.a = 1; bus.b = 1; bus.finished = 0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("in_reset", bus.encender, 1'b0);
    end
    rst = 1'b1;
    step(1,1,0); check("rst_rel_arm", bus.encender, m_on);
    step(1,1,0); check("rst_held", bus.encender, m_on);
    step(0,0,0);
    for (int i = 0; i < N; i++) begin
      step(0,1,0); check("rst_cnt", bus.encender, (i == N-1));
      step(0,0,0);
    end
    step(0,0,1); check("rst_fin", bus.encender, 1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].a, tbl[i].b, tbl[i].f);
      check($sformatf("tbl%0d", i), bus.encender, tbl[i].enc);
    end

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0,3) == 0, $urandom_range(0,1) == 1, $urandom_range(0,9) == 0);
      check("rand", bus.encender, m_on);
    end

    // asynchronous reset while ON
    step(0,0,1);
    step(1,0,0);
    for (int i = 0; i < N; i++) begin
      step(0,1,0);
      step(0,0,0);
    end
    check("pre_rst_on", bus.encender, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_rst", bus.encender, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(0,1,0); check("post_rst_b", bus.encender, m_on);
    step(0,0,0);
    step(1,0,0);
    for (int i = 0; i < N; i++) begin
      step(0,1,0); check("post_rst_seq", bus.encender, (i == N-1));
      step(0,0,0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/quiz3_digitales.md
# quiz3_digitales

Sequence-controlled enable block. A rising edge on `a` arms the controller. A programmable number of rising edges on `b` then asserts the `encender` (turn-on) output. `encender` holds until `finished` is seen, and the block then returns to idle. It sits between debounced, clock-synchronous push-button inputs and the load it switches on.

## Interface
- `N_PULSES`, default 3: number of `b` rising edges, counted after arming, that are required to assert `encender`. Legal range 1–255.
- `clk` in 1: single system clock; all logic is on the rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-low (`rst` = 0 resets, release is synchronous to `clk`).
- `a` in 1: arm/restart request, level input, synchronous to `clk`.
- `b` in 1: count pulse, level input, synchronous to `clk`.
- `finished` in 1: end-of-operation; returns the block to idle.
- `encender` out 1: enable output, registered, driven from state.

## Operation
- Edge detection:
  - Registers `a_q`, `b_q` hold the previous-cycle samples.
  - `a_rise = a & ~a_q`, `b_rise = b & ~b_q`.
  - During reset, `a_q` and `b_q` clear to 0. An input held high through reset release therefore counts as one edge on the first active cycle.
- Pulse counter: `cnt`, width $clog2(N_PULSES+1). It clears to 0 in reset and on every entry to ARMED. It never exceeds `N_PULSES`.
- State machine. States are IDLE, ARMED and ON; the reset state is IDLE.
- IDLE:
  - `a_rise` goes to ARMED with `cnt` = 0.
  - `b_rise` and `finished` are ignored.
- ARMED:
  - Priority 1: `finished` = 1 goes to IDLE (abort).
  - Priority 2: `a_rise` restarts, so `cnt` becomes 0 and the state stays ARMED. This applies even when `b_rise` occurs in the same cycle.
  - Priority 3: on `b_rise`, if `cnt` = `N_PULSES`-1 go to ON; otherwise `cnt` increments.
- ON:
  - `finished` = 1 goes to IDLE.
  - `a` and `b` are ignored.
- Output: `encender` = 1 only in state ON; it is 0 in IDLE and ARMED.
- Reset while in any state forces IDLE, `cnt` = 0 and `encender` = 0 immediately, without waiting for a clock edge.

## Timing
- Reset values: `encender` = 0, state = IDLE, `cnt` = 0, `a_q` = `b_q` = 0.
- Edge-detect latency: a level change sampled at posedge k is recognised at posedge k. The resulting state or count update is visible after posedge k.
- `encender` rises in the cycle after the posedge that samples the `N_PULSES`-th `b` rising edge. That is one clock of latency; there is no combinational path from input to output.
- `encender` falls in the cycle after the posedge that samples `finished` = 1.
- `finished` is level-sensitive. Holding it high keeps IDLE, and an `a_rise` arriving while `finished` = 1 in IDLE still arms the block (`finished` has no effect in IDLE).
- Input levels held high for multiple cycles count as a single edge. A new edge requires at least one low sample in between.
- Back-to-back edges are allowed: a pattern of b = 1,0,1,0,1 on consecutive cycles yields 3 edges.

## Test plan
- Reset check: hold `rst` = 0 with `a` = `b` = 1, then release -> `encender` = 0 throughout reset. The first active cycle registers `a_rise`, which arms the block, and the pending `b` does not count.
- Nominal sequence (`N_PULSES` = 3): a pulse, then three separate b pulses each 2 cycles high/2 low -> `encender` = 1 from the cycle after the third `b` rise. Then a `finished` pulse -> `encender` = 0 the next cycle and state IDLE.
- Restart: a pulse, b, b, a pulse, then `finished` -> `encender` never asserts. Follow with a, b, b, b -> `encender` = 1 after the 3rd `b` rise.
- Ignored inputs: b pulses while IDLE -> no effect, and a subsequent a plus 3 b pulses is still needed. Extra a/b pulses in ON -> `encender` stays 1.
- Simultaneous edges: in ARMED with `cnt` = 2, `a` and `b` rise in the same cycle -> `cnt` = 0 and `encender` stays 0. In ARMED, `finished` together with the final `b_rise` -> IDLE and `encender` stays 0.
- Asynchronous reset mid-ON: drop `rst` between clock edges -> `encender` goes to 0 immediately, with no clock required. After release, the block needs a full a + 3 b sequence again.
